// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: reset vector, NOP encoding, fetch FSM states
// and the IF/ID bundle layout shared by fetch and decode.
package pipeline_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    localparam int IFID_INSTR_W = 32;
    localparam int IFID_PC4_W   = 32;
    localparam int IFID_W       = IFID_INSTR_W + IFID_PC4_W + 1;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic                    valid;
        logic [IFID_PC4_W-1:0]   pc4;
        logic [IFID_INSTR_W-1:0] instr;
    } ifid_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline register with synchronous reset, flush (clear) and stall
// (hold). Clear takes priority over hold so a flush always inserts a bubble.
module ifid_reg
    import pipeline_pkg::*;
#(
    parameter int           W         = IFID_W,
    parameter logic [W-1:0] CLEAR_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_hold,
    input  logic         i_clear,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= CLEAR_VAL;
        end else if (i_clear) begin
            r_q <= CLEAR_VAL;
        end else if (!i_hold) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a synchronous-read instruction
// memory, and delivers a registered IF/ID bundle with stall replay and redirect squash.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [31:0] fetch_count,
    output logic [31:0] squash_count,
    output logic [1:0]  state_o
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_req_pc;
    logic         r_req_vld;
    logic [31:0]  r_fetch_count;
    logic [31:0]  r_squash_count;
    logic [31:0]  w_imem_addr;
    logic         w_hold;
    ifid_t        w_ifid_d;
    ifid_t        w_ifid_q;

    // Redirect beats everything; BOOT issues the reset vector once; a stall replays.
    always_comb begin
        w_imem_addr = r_req_pc + 32'd4;
        if (redirect_i) begin
            w_imem_addr = word_align(redirect_pc_i);
        end else if (r_state == BOOT) begin
            w_imem_addr = RESET_PC;
        end else if (stall_i) begin
            w_imem_addr = r_req_pc;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BOOT:    w_state_next = RUN;
            RUN:     if (stall_i && !redirect_i) w_state_next = STALL;
            STALL:   if (!stall_i || redirect_i) w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= BOOT;
            r_req_pc  <= RESET_PC;
            r_req_vld <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_req_pc  <= w_imem_addr;
            r_req_vld <= 1'b1;
        end
    end

    // BOOT ignores stall; req_vld is still 0 there, so the capture is a bubble.
    assign w_hold = stall_i && !redirect_i && (r_state != BOOT);

    always_comb begin
        w_ifid_d.valid = r_req_vld;
        w_ifid_d.pc4   = r_req_pc + 32'd4;
        w_ifid_d.instr = r_req_vld ? imem_rdata : NOP_INSTR;
    end

    ifid_reg #(
        .W         (IFID_W),
        .CLEAR_VAL ('0)
    ) u_ifid_reg (
        .clk     (clk),
        .reset   (reset),
        .i_hold  (w_hold),
        .i_clear (redirect_i),
        .i_d     (w_ifid_d),
        .o_q     (w_ifid_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count  <= 32'd0;
            r_squash_count <= 32'd0;
        end else if (redirect_i) begin
            if (r_req_vld) r_squash_count <= r_squash_count + 32'd1;
        end else if (!w_hold && r_req_vld) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign imem_addr    = w_imem_addr;
    assign ifid_instr   = w_ifid_q.instr;
    assign ifid_pc4     = w_ifid_q.pc4;
    assign ifid_valid   = w_ifid_q.valid;
    assign fetch_count  = r_fetch_count;
    assign squash_count = r_squash_count;
    assign state_o      = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table for the documented
// scenarios, then randomized stall/redirect/reset traffic against a reference model.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [31:0] fetch_count;
    logic [31:0] squash_count;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .ifid_instr    (ifid_instr),
        .ifid_pc4      (ifid_pc4),
        .ifid_valid    (ifid_valid),
        .fetch_count   (fetch_count),
        .squash_count  (squash_count),
        .state_o       (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory image: word i holds 32'h1000_0000 + i.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000_0000 + {2'b00, addr[31:2]};
    endfunction

    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: the fetch stream as "which address is in flight",
    // "what is sitting in IF/ID" and two event tallies.
    logic        m_known = 1'b0;
    logic [31:0] m_fly_addr;
    logic        m_fly_vld;
    logic        m_boot;
    logic        m_stalled;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic [31:0] m_fc;
    logic [31:0] m_sc;
    logic [31:0] samp_addr;

    function automatic logic [1:0] model_state();
        if (m_boot) return 2'd0;
        return m_stalled ? 2'd2 : 2'd1;
    endfunction

    task automatic step(input logic rst, input logic stall, input logic redir,
                        input logic [31:0] tgt);
        logic [31:0] exp_addr;
        reset         = rst;
        stall_i       = stall;
        redirect_i    = redir;
        redirect_pc_i = tgt;
        #1;
        samp_addr = imem_addr;
        if (redir)       exp_addr = tgt & 32'hFFFF_FFFC;
        else if (m_boot) exp_addr = 32'h0000_0000;
        else if (stall)  exp_addr = m_fly_addr;
        else             exp_addr = m_fly_addr + 32'd4;
        if (m_known) check("model imem_addr", imem_addr, exp_addr);
        @(posedge clk);
        #1;
        if (rst) begin
            m_fly_addr = 32'h0; m_fly_vld = 1'b0; m_boot = 1'b1; m_stalled = 1'b0;
            m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0; m_fc = 32'h0; m_sc = 32'h0;
            m_known = 1'b1;
        end else begin
            if (redir) begin
                m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
                if (m_fly_vld) m_sc = m_sc + 1;
            end else if (!(stall && !m_boot)) begin
                m_valid = m_fly_vld;
                m_instr = m_fly_vld ? mem_word(m_fly_addr) : 32'h0;
                m_pc4   = m_fly_addr + 32'd4;
                if (m_fly_vld) m_fc = m_fc + 1;
            end
            m_stalled  = !m_boot && stall && !redir;
            m_boot     = 1'b0;
            m_fly_addr = exp_addr;
            m_fly_vld  = 1'b1;
        end
        if (m_known) begin
            check("model ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
            check("model ifid_instr", ifid_instr, m_instr);
            check("model ifid_pc4", ifid_pc4, m_pc4);
            check("model state_o", {30'b0, state_o}, {30'b0, model_state()});
            check("model fetch_count", fetch_count, m_fc);
            check("model squash_count", squash_count, m_sc);
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic        rst, stall, redir;
        logic [31:0] tgt;
        logic        chk_addr;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr, pc4;
        logic [1:0]  state;
        logic [31:0] fcnt, scnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, stall, redir, input logic [31:0] tgt,
                                input logic chk, input logic [31:0] addr, input logic valid,
                                input logic [31:0] instr, pc4, input logic [1:0] st,
                                input logic [31:0] fc, sc);
        vec_t v;
        v.rst = rst; v.stall = stall; v.redir = redir; v.tgt = tgt;
        v.chk_addr = chk; v.addr = addr; v.valid = valid; v.instr = instr;
        v.pc4 = pc4; v.state = st; v.fcnt = fc; v.scnt = sc;
        return v;
    endfunction

    initial begin
        reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;

        // rst stall redir target | chk addr | valid instr pc4 state fc sc (after the edge)
        vecs.push_back(mk(1,0,0,0,            0,32'h0,        0,32'h0,        32'h0,        0,0,0)); // reset
        vecs.push_back(mk(0,0,0,0,            1,32'h0,        0,32'h0,        32'h4,        1,0,0)); // cycle 0 BOOT
        vecs.push_back(mk(0,0,0,0,            1,32'h4,        1,32'h1000_0000,32'h4,        1,1,0));
        vecs.push_back(mk(0,0,0,0,            1,32'h8,        1,32'h1000_0001,32'h8,        1,2,0));
        vecs.push_back(mk(0,0,0,0,            1,32'hC,        1,32'h1000_0002,32'hC,        1,3,0));
        vecs.push_back(mk(0,1,0,0,            1,32'hC,        1,32'h1000_0002,32'hC,        2,3,0)); // stall x3
        vecs.push_back(mk(0,1,0,0,            1,32'hC,        1,32'h1000_0002,32'hC,        2,3,0));
        vecs.push_back(mk(0,1,0,0,            1,32'hC,        1,32'h1000_0002,32'hC,        2,3,0));
        vecs.push_back(mk(0,0,0,0,            1,32'h10,       1,32'h1000_0003,32'h10,       1,4,0)); // replay once
        vecs.push_back(mk(0,0,1,32'h40,       1,32'h40,       0,32'h0,        32'h0,        1,4,1)); // redirect
        vecs.push_back(mk(0,0,0,0,            1,32'h44,       1,32'h1000_0010,32'h44,       1,5,1));
        vecs.push_back(mk(0,1,1,32'h83,       1,32'h80,       0,32'h0,        32'h0,        1,5,2)); // redir+stall
        vecs.push_back(mk(0,0,0,0,            1,32'h84,       1,32'h1000_0020,32'h84,       1,6,2));
        vecs.push_back(mk(0,1,0,0,            1,32'h84,       1,32'h1000_0020,32'h84,       2,6,2));
        vecs.push_back(mk(0,0,1,32'hFFFF_FFF8,1,32'hFFFF_FFF8,0,32'h0,        32'h0,        1,6,3)); // redirect out of STALL
        vecs.push_back(mk(0,0,0,0,            1,32'hFFFF_FFFC,1,32'h4FFF_FFFE,32'hFFFF_FFFC,1,7,3));
        vecs.push_back(mk(0,0,0,0,            1,32'h0,        1,32'h4FFF_FFFF,32'h0,        1,8,3)); // wrap
        vecs.push_back(mk(0,0,0,0,            1,32'h4,        1,32'h1000_0000,32'h4,        1,9,3));
        vecs.push_back(mk(1,0,0,0,            1,32'h8,        0,32'h0,        32'h0,        0,0,0)); // mid-stream reset
        vecs.push_back(mk(0,1,0,0,            1,32'h0,        0,32'h0,        32'h4,        1,0,0)); // BOOT ignores stall
        vecs.push_back(mk(0,0,0,0,            1,32'h4,        1,32'h1000_0000,32'h4,        1,1,0));
        vecs.push_back(mk(0,0,0,0,            1,32'h8,        1,32'h1000_0001,32'h8,        1,2,0));

        @(negedge clk);
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].tgt);
            if (vecs[i].chk_addr) check($sformatf("vec%0d imem_addr", i), samp_addr, vecs[i].addr);
            check($sformatf("vec%0d ifid_valid", i), {31'b0, ifid_valid}, {31'b0, vecs[i].valid});
            check($sformatf("vec%0d ifid_instr", i), ifid_instr, vecs[i].instr);
            check($sformatf("vec%0d ifid_pc4", i), ifid_pc4, vecs[i].pc4);
            check($sformatf("vec%0d state_o", i), {30'b0, state_o}, {30'b0, vecs[i].state});
            check($sformatf("vec%0d fetch_count", i), fetch_count, vecs[i].fcnt);
            check($sformatf("vec%0d squash_count", i), squash_count, vecs[i].scnt);
        end

        // Multi-cycle corner: long stall held across a redirect, then a stall right after.
        step(0, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        step(0, 1, 1, 32'h0000_0202);
        check("seq redirect during stall addr", samp_addr, 32'h0000_0200);
        check("seq redirect during stall bubble", {31'b0, ifid_valid}, 32'h0);
        step(0, 1, 0, 32'h0);
        check("seq stall after redirect replays target", samp_addr, 32'h0000_0200);
        check("seq stall after redirect bubble held", {31'b0, ifid_valid}, 32'h0);
        step(0, 0, 0, 32'h0);
        check("seq target delivered", ifid_instr, 32'h1000_0080);
        check("seq target pc4", ifid_pc4, 32'h0000_0204);

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            logic r, s, d;
            logic [31:0] t;
            r = ($urandom_range(0, 99) < 1);
            s = ($urandom_range(0, 99) < 30);
            d = ($urandom_range(0, 99) < 12);
            t = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            step(r, s, d, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
